// File: rtl/pic_regfile_if.sv
// Decoder/ALU-facing bus of the general-purpose register file.
interface pic_regfile_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] alu_bus;
    logic [DATA_W-1:0] ram_bus;
    logic [ADDR_W-1:0] fsr;
    logic              ready;

    modport master (
        output we, addr, alu_bus,
        input  ram_bus, fsr, ready
    );

    modport slave (
        input  we, addr, alu_bus,
        output ram_bus, fsr, ready
    );
endinterface

// File: rtl/pic_regfile.sv
// Register file with INDF/FSR indirect addressing, registered read port and post-reset clear sweep.
// Optional macro RAM_BYPASS_EN selects write-first reads; default is read-first.
module pic_regfile #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned INDF_ADDR = 0,
    parameter int unsigned FSR_ADDR  = 4,
    parameter int unsigned RST_VAL   = 0
) (
    input logic         clk,
    input logic         rst,
    pic_regfile_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] ram_bus_q;
    logic [ADDR_W-1:0] fsr_q;
    logic              ready_q;

    logic [DATA_W-1:0] ram [DEPTH];

    logic [ADDR_W-1:0] ea;
    logic              indf_self;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_data;
    logic              fsr_we;

    // Effective address, array write port selection and next read value
    always_comb begin
        ea        = bus.addr;
        indf_self = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = clr_ptr;
        mem_wdata = DATA_W'(RST_VAL);
        rd_data   = '0;
        fsr_we    = 1'b0;

        if (bus.addr == ADDR_W'(INDF_ADDR)) begin
            ea = fsr_q;
        end
        indf_self = (bus.addr == ADDR_W'(INDF_ADDR)) && (fsr_q == ADDR_W'(INDF_ADDR));

        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_ptr;
            mem_wdata = DATA_W'(RST_VAL);
        end else begin
            mem_we    = bus.we && !indf_self;
            mem_addr  = ea;
            mem_wdata = bus.alu_bus;
            fsr_we    = bus.we && !indf_self && (ea == ADDR_W'(FSR_ADDR));
`ifdef RAM_BYPASS_EN
            rd_data   = indf_self ? '0 : (bus.we ? bus.alu_bus : ram[ea]);
`else
            rd_data   = indf_self ? '0 : ram[ea];
`endif
        end
    end

    // Storage array: no reset, initialised by the clear sweep
    always_ff @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    // Control state, read register and FSR shadow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_CLEAR;
            clr_ptr   <= '0;
            ram_bus_q <= '0;
            fsr_q     <= ADDR_W'(RST_VAL);
            ready_q   <= 1'b0;
        end else if (state == ST_CLEAR) begin
            ram_bus_q <= '0;
            if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                state   <= ST_RUN;
                ready_q <= 1'b1;
            end else begin
                clr_ptr <= clr_ptr + ADDR_W'(1);
            end
        end else begin
            ram_bus_q <= rd_data;
            if (fsr_we) begin
                fsr_q <= ADDR_W'(bus.alu_bus);
            end
        end
    end

    assign bus.ram_bus = ram_bus_q;
    assign bus.fsr     = fsr_q;
    assign bus.ready   = ready_q;
endmodule
